// File: rtl/virtio_pkg.sv
// rtl/virtio_pkg.sv - shared types and constants for the virtio avail-ring tracker
package virtio_pkg;

  localparam int QNUM_W     = 2;
  localparam int IDX_W      = 16;
  localparam int NUM_QUEUES = 3;

  typedef logic [QNUM_W-1:0] qsel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after a pointer
module rr_arbiter
  import virtio_pkg::*;
#(
  parameter int N = NUM_QUEUES
) (
  input  logic [N-1:0] req,
  input  qsel_t        ptr,
  output logic         grant_valid,
  output qsel_t        grant_q
);

  int idx;

  // Scan offsets from the highest down so the smallest offset from ptr wins last
  always_comb begin
    grant_valid = 1'b0;
    grant_q     = '0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx[QNUM_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_q     = idx[QNUM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/virtio_avail_ring_tracker.sv
// rtl/virtio_avail_ring_tracker.sv - doorbell capture, avail.idx fetch and per-queue availability
module virtio_avail_ring_tracker #(
  parameter int NUM_QUEUES = 3,
  parameter int IDX_W      = 16
) (
  input  logic                        clk,
  input  logic                        csr_rst,
  input  logic                        notify_valid,
  input  virtio_pkg::qsel_t           notify_qsel,
  output logic                        rd_req,
  output virtio_pkg::qsel_t           rd_qsel,
  input  logic                        rd_ack,
  input  logic [IDX_W-1:0]            rd_avail_idx,
  input  logic                        desc_take,
  input  virtio_pkg::qsel_t           desc_qsel,
  output logic [NUM_QUEUES-1:0]       queue_notify_pending,
  output logic [NUM_QUEUES-1:0]       queue_notify_clr,
  output logic [NUM_QUEUES-1:0]       ring_available_pending,
  output logic [NUM_QUEUES*IDX_W-1:0] next_avail_idx
);

  import virtio_pkg::*;

  fsm_state_t            state;
  fsm_state_t            state_nxt;
  qsel_t                 cur_q;
  qsel_t                 rr_ptr;
  logic                  grant_valid;
  qsel_t                 grant_q;
  logic                  ack_fire;

  logic [IDX_W-1:0]      avail_idx   [NUM_QUEUES];
  logic [IDX_W-1:0]      next_idx    [NUM_QUEUES];
  logic [IDX_W-1:0]      avail_upd   [NUM_QUEUES];
  logic [IDX_W-1:0]      next_upd    [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] set_vec;
  logic [NUM_QUEUES-1:0] ack_vec;
  logic [NUM_QUEUES-1:0] avail_nz;

  rr_arbiter #(.N(NUM_QUEUES)) u_rr_arbiter (
    .req         (queue_notify_pending),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_q     (grant_q)
  );

  // A completion only counts while a read is actually outstanding
  assign ack_fire = (state == ST_REQ) && rd_ack;

  // FSM state register
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: start a read when something is pending, finish on ack
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_valid) state_nxt = ST_REQ;
      ST_REQ:  if (rd_ack)      state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request held for the whole REQ state on the latched queue
  always_comb begin
    rd_req  = (state == ST_REQ);
    rd_qsel = cur_q;
  end

  // Latch the granted queue and advance the round-robin pointer past it on ack
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      cur_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == ST_IDLE && grant_valid) cur_q <= grant_q;
      if (ack_fire) rr_ptr <= (cur_q == qsel_t'(NUM_QUEUES - 1)) ? '0 : cur_q + 2'd1;
    end
  end

  // Per-queue doorbell set, service clear, and next index values
  always_comb begin
    set_vec  = '0;
    ack_vec  = '0;
    avail_nz = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      set_vec[q]   = notify_valid && (notify_qsel == qsel_t'(q));
      ack_vec[q]   = ack_fire && (cur_q == qsel_t'(q));
      avail_upd[q] = ack_vec[q] ? rd_avail_idx : avail_idx[q];
      // Take is judged on the count before this cycle's ack lands
      if (desc_take && (desc_qsel == qsel_t'(q)) && (avail_idx[q] != next_idx[q]))
        next_upd[q] = next_idx[q] + 1'b1;
      else
        next_upd[q] = next_idx[q];
      avail_nz[q]  = ((avail_upd[q] - next_upd[q]) != '0);
    end
  end

  // Doorbell pending: a new doorbell wins over a same-cycle service clear
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      queue_notify_pending <= '0;
      queue_notify_clr     <= '0;
    end else begin
      queue_notify_pending <= (queue_notify_pending & ~ack_vec) | set_vec;
      queue_notify_clr     <= ack_vec;
    end
  end

  // Driver/device indices and the availability flag derived from them
  always_ff @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        avail_idx[q] <= '0;
        next_idx[q]  <= '0;
      end
      ring_available_pending <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        avail_idx[q] <= avail_upd[q];
        next_idx[q]  <= next_upd[q];
      end
      ring_available_pending <= avail_nz;
    end
  end

  // Flatten device indices onto the output bus
  always_comb begin
    next_avail_idx = '0;
    for (int q = 0; q < NUM_QUEUES; q++) next_avail_idx[q*IDX_W +: IDX_W] = next_idx[q];
  end

endmodule

// File: tb/tb_virtio_avail_ring_tracker.sv
// tb/tb_virtio_avail_ring_tracker.sv - self-checking bench for virtio_avail_ring_tracker
module tb_virtio_avail_ring_tracker;

  logic        clk = 1'b0;
  logic        csr_rst;
  logic        notify_valid = 1'b0;
  logic [1:0]  notify_qsel = '0;
  logic        rd_req;
  logic [1:0]  rd_qsel;
  logic        rd_ack = 1'b0;
  logic [15:0] rd_avail_idx = '0;
  logic        desc_take = 1'b0;
  logic [1:0]  desc_qsel = '0;
  logic [2:0]  queue_notify_pending;
  logic [2:0]  queue_notify_clr;
  logic [2:0]  ring_available_pending;
  logic [47:0] next_avail_idx;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding read queue (-1 = none), pointer, bits and indices
  int       m_busy;
  int       m_ptr;
  bit [2:0] m_pend, m_clr, m_ap;
  int       m_avail [3];
  int       m_next  [3];

  virtio_avail_ring_tracker #(.NUM_QUEUES(3), .IDX_W(16)) dut (
    .clk                    (clk),
    .csr_rst                (csr_rst),
    .notify_valid           (notify_valid),
    .notify_qsel            (notify_qsel),
    .rd_req                 (rd_req),
    .rd_qsel                (rd_qsel),
    .rd_ack                 (rd_ack),
    .rd_avail_idx           (rd_avail_idx),
    .desc_take              (desc_take),
    .desc_qsel              (desc_qsel),
    .queue_notify_pending   (queue_notify_pending),
    .queue_notify_clr       (queue_notify_clr),
    .ring_available_pending (ring_available_pending),
    .next_avail_idx         (next_avail_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int cnt(input int q);
    return (m_avail[q] - m_next[q]) & 16'hFFFF;
  endfunction

  always @(posedge clk or posedge csr_rst) begin
    if (csr_rst) begin
      m_busy = -1; m_ptr = 0; m_pend = '0; m_clr = '0; m_ap = '0;
      for (int q = 0; q < 3; q++) begin m_avail[q] = 0; m_next[q] = 0; end
    end else begin
      automatic bit [2:0] np = m_pend;
      automatic int nb = m_busy;
      automatic bit take_ok = desc_take && (desc_qsel < 3) && (cnt(int'(desc_qsel)) != 0);
      m_clr = '0;
      if (m_busy >= 0 && rd_ack) begin
        m_avail[m_busy] = int'(rd_avail_idx);
        np[m_busy] = 1'b0;
        m_clr[m_busy] = 1'b1;
        m_ptr = (m_busy + 1) % 3;
        nb = -1;
      end else if (m_busy < 0) begin
        for (int k = 2; k >= 0; k--)
          if (m_pend[(m_ptr + k) % 3]) nb = (m_ptr + k) % 3;
      end
      if (take_ok) m_next[desc_qsel] = (m_next[desc_qsel] + 1) & 16'hFFFF;
      if (notify_valid && notify_qsel < 3) np[notify_qsel] = 1'b1;
      m_pend = np;
      m_busy = nb;
      for (int q = 0; q < 3; q++) m_ap[q] = (cnt(q) != 0);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (csr_rst === 1'b0) begin
      chk("rd_req", 64'(rd_req), 64'(m_busy >= 0));
      if (m_busy >= 0) chk("rd_qsel", 64'(rd_qsel), 64'(m_busy));
      chk("notify_pending", 64'(queue_notify_pending), 64'(m_pend));
      chk("notify_clr", 64'(queue_notify_clr), 64'(m_clr));
      chk("avail_pending", 64'(ring_available_pending), 64'(m_ap));
      chk("next_avail_idx", 64'(next_avail_idx),
          64'({m_next[2][15:0], m_next[1][15:0], m_next[0][15:0]}));
    end
  end

  task automatic notify(input logic [1:0] q);
    @(negedge clk); notify_valid = 1'b1; notify_qsel = q;
    @(negedge clk); notify_valid = 1'b0;
  endtask

  task automatic take_n(input logic [1:0] q, input int n);
    @(negedge clk); desc_take = 1'b1; desc_qsel = q;
    repeat (n) @(negedge clk);
    desc_take = 1'b0;
  endtask

  task automatic wait_req(input logic [1:0] q);
    int n = 0;
    while (!rd_req && n < 40) begin @(negedge clk); n++; end
    chk("wait_rd_req", 64'(rd_req), 64'd1);
    chk("req_qsel", 64'(rd_qsel), 64'(q));
  endtask

  task automatic ack(input logic [15:0] v);
    rd_ack = 1'b1; rd_avail_idx = v;
    @(negedge clk); rd_ack = 1'b0;
  endtask

  initial begin
    csr_rst = 1'b1;
    repeat (3) @(negedge clk);
    csr_rst = 1'b0;
    chk("reset_outputs", 64'({rd_req, queue_notify_pending, queue_notify_clr, ring_available_pending}), 64'd0);
    chk("reset_next_idx", 64'(next_avail_idx), 64'd0);

    // Illegal selectors change nothing
    notify(2'd3);
    take_n(2'd3, 2);
    repeat (2) @(negedge clk);
    chk("illegal_pending", 64'(queue_notify_pending), 64'd0);
    chk("illegal_rd_req", 64'(rd_req), 64'd0);

    // Basic flow on q1
    notify(2'd1);
    wait_req(2'd1);
    ack(16'd5);
    chk("basic_clr", 64'(queue_notify_clr), 64'b010);
    chk("basic_avail", 64'(ring_available_pending), 64'b010);
    take_n(2'd1, 4);
    chk("basic_4_takes_pending", 64'(ring_available_pending), 64'b010);
    take_n(2'd1, 1);
    chk("basic_5_takes_idx", 64'(next_avail_idx[31:16]), 64'd5);
    chk("basic_5_takes_pending", 64'(ring_available_pending), 64'b000);
    take_n(2'd1, 1);
    chk("basic_6th_ignored", 64'(next_avail_idx[31:16]), 64'd5);

    // Wrap on q0: bring next_avail_idx to 0xFFFF, then avail 0x0001 gives count 2
    notify(2'd0);
    wait_req(2'd0);
    ack(16'hFFFF);
    take_n(2'd0, 65535);
    chk("wrap_preload", 64'(next_avail_idx[15:0]), 64'hFFFF);
    notify(2'd0);
    wait_req(2'd0);
    ack(16'h0001);
    chk("wrap_count2_pending", 64'(ring_available_pending[0]), 64'd1);
    take_n(2'd0, 2);
    chk("wrap_idx", 64'(next_avail_idx[15:0]), 64'h0001);
    chk("wrap_pending", 64'(ring_available_pending[0]), 64'd0);

    // Ack and take on the same queue in one cycle
    notify(2'd1);
    wait_req(2'd1);
    ack(16'd8);
    notify(2'd1);
    wait_req(2'd1);
    desc_take = 1'b1; desc_qsel = 2'd1;
    ack(16'd12);
    desc_take = 1'b0;
    chk("ack_take_idx", 64'(next_avail_idx[31:16]), 64'd6);
    chk("ack_take_pending", 64'(ring_available_pending[1]), 64'd1);

    // Round robin burst, then re-notify q0 during q2 service
    @(negedge clk); notify_valid = 1'b1; notify_qsel = 2'd0;
    @(negedge clk); notify_qsel = 2'd1;
    @(negedge clk); notify_qsel = 2'd2;
    @(negedge clk); notify_valid = 1'b0;
    wait_req(2'd0); ack(16'd10);
    wait_req(2'd1); ack(16'd20);
    wait_req(2'd2);
    notify_valid = 1'b1; notify_qsel = 2'd0;
    @(negedge clk); notify_valid = 1'b0;
    ack(16'd3);
    wait_req(2'd0); ack(16'd11);

    // Collision: doorbell on q2 in the same cycle as its ack
    notify(2'd2);
    wait_req(2'd2);
    notify_valid = 1'b1; notify_qsel = 2'd2;
    ack(16'd4);
    notify_valid = 1'b0;
    chk("collision_pending", 64'(queue_notify_pending[2]), 64'd1);
    chk("collision_clr", 64'(queue_notify_clr[2]), 64'd1);
    wait_req(2'd2);
    ack(16'd6);

    // Reset while a read is outstanding
    notify(2'd1);
    wait_req(2'd1);
    #3 csr_rst = 1'b1;
    #1;
    chk("rst_rd_req", 64'(rd_req), 64'd0);
    chk("rst_outputs", 64'({queue_notify_pending, queue_notify_clr, ring_available_pending}), 64'd0);
    chk("rst_next_idx", 64'(next_avail_idx), 64'd0);
    @(negedge clk); csr_rst = 1'b0;
    rd_ack = 1'b1; rd_avail_idx = 16'd9;
    @(negedge clk); rd_ack = 1'b0;
    chk("late_ack_ignored", 64'(ring_available_pending), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/virtio_avail_ring_tracker.md
# virtio_avail_ring_tracker

Per-virtqueue bookkeeping block for the virtio FPGA data path. It sits between the virtio CSR block and the descriptor fetch engine. It records queue-notify doorbells and fetches each notified queue's driver `avail.idx` through a simple read port. It tracks the device-side `next_avail_idx` and flags which queues hold unconsumed available-ring entries.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `NUM_QUEUES`, 3: number of virtqueues, each indexed by a 2-bit selector.
- `IDX_W`, 16: ring index width.

Ports:
- `clk` in 1: CSR/data-path clock.
- `csr_rst` in 1: asynchronous, active-high reset.
- `notify_valid` in 1: one-cycle doorbell strobe from the CSR QueueNotify write.
- `notify_qsel` in 2: queue number of the doorbell.
- `rd_req` out 1: avail-idx read request; held until `rd_ack`.
- `rd_qsel` out 2: queue being read; stable while `rd_req` is high.
- `rd_ack` in 1: read completion strobe.
- `rd_avail_idx` in IDX_W: driver `avail.idx`; valid with `rd_ack`.
- `desc_take` in 1: consumer took one available entry.
- `desc_qsel` in 2: queue for `desc_take`.
- `queue_notify_pending` out NUM_QUEUES: doorbell seen, not yet serviced.
- `queue_notify_clr` out NUM_QUEUES: one-cycle pulse when a pending notify is serviced.
- `ring_available_pending` out NUM_QUEUES: queue has unconsumed entries.
- `next_avail_idx` out NUM_QUEUES*IDX_W: per-queue device index; queue q occupies bits [q*IDX_W +: IDX_W].

## Operation
- **Reset values.** All outputs are 0, `next_avail_idx` = 0, latched `avail_idx[q]` = 0, the round-robin pointer = 0, and the FSM is in IDLE.
- **Doorbell.** `notify_valid` with `notify_qsel`<NUM_QUEUES sets `queue_notify_pending[q]`. A selector of 3 (or any value ≥NUM_QUEUES) is ignored.
- **Set/clear precedence.** Set has priority over clear in the same cycle. The notify stays pending and is re-serviced.
- **FSM states.**
  - IDLE: if any `queue_notify_pending` bit is set, pick the first pending queue at or after the round-robin pointer, drive `rd_qsel`, and go to REQ.
  - REQ: `rd_req`=1. On `rd_ack`:
    - latch `avail_idx[q]` = `rd_avail_idx`;
    - clear `queue_notify_pending[q]` and pulse `queue_notify_clr[q]`;
    - set pointer = q+1 mod NUM_QUEUES;
    - return to IDLE.
  - Only one read is outstanding at a time.
- **Availability.**
  - Compute `count[q]` = (`avail_idx[q]` − `next_avail_idx[q]`) mod 2^IDX_W.
  - `ring_available_pending[q]` is registered as (`count[q]` != 0) on every update of either index.
  - A driver index that moves backwards is treated modularly, with no error detection.
- **Consumption.**
  - `desc_take` with a valid `desc_qsel` and `count`!=0 increments `next_avail_idx[q]`, wrapping 0xFFFF→0x0000.
  - `desc_take` with `count`==0 or an invalid selector is ignored.
- **Ack and take on the same queue in one cycle.** Both apply: the new `avail_idx` and the incremented `next_avail_idx`. Pending is computed from the post-update values.

## Timing
- All state is registered; every effect is visible the cycle after the causing edge.
- Doorbell → `rd_req`: 2 cycles minimum (pending set, then IDLE→REQ).
- `rd_ack` may arrive in the same cycle `rd_req` first asserts.
- `queue_notify_clr` pulses exactly one cycle, coincident with the pending clear.
- Reset mid-REQ drops `rd_req` asynchronously. A late `rd_ack` while in IDLE is ignored.

## Structure
- Shared package `virtio_pkg`: `QNUM_W`=2, `IDX_W`=16, `NUM_QUEUES`=3, the FSM state enum, and the `qsel_t` typedef.
- Natural sub-module `rr_arbiter`: round-robin pick over NUM_QUEUES request bits with a pointer input. The rest stays in the top level.

## Test plan
- **Reset:** assert `csr_rst` mid-REQ → all outputs 0, `rd_req` low immediately.
- **Basic:**
  - notify q1 → `rd_req`=1 with `rd_qsel`=1;
  - ack with 5 → `queue_notify_clr`=3'b010 pulse, `ring_available_pending`=3'b010;
  - five `desc_take` on q1 → `next_avail_idx[1]`=5 and pending clears on the 5th;
  - a 6th take is ignored.
- **Wrap:** preload `next_avail_idx[0]`=0xFFFF via takes, ack `avail_idx`=0x0001 → count 2; two takes → index 0x0001, pending 0.
- **Round robin:** notify q0, q1, q2 in one burst → reads served in order 0, 1, 2; re-notify q0 during q2 service → q0 served next.
- **Collision:** notify q2 in the same cycle as its `rd_ack` → `queue_notify_pending[2]` stays 1 and a second read of q2 follows.
- **Illegal:** `notify_qsel`=3 or `desc_qsel`=3 → no state change.
